riscv_multicycle_ctrl: RTL and testbench
========================================

RISCV_MULTICYCLE_CTRL -- requirements
Module: riscv_multicycle_ctrl

Interface
REQ-001 SHALL have parameter COUNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port opcode  input  7  instruction[6:0] from datapath IR; valid from DECODE onward.
REQ-005 SHALL have port funct3  input  3  instruction[14:12] from IR.
REQ-006 SHALL have port zero  input  1  ALU zero flag, combinational.
REQ-007 SHALL have port mem_ready  input  1  memory completes the current request this cycle.
REQ-008 SHALL have outputs pc_write, ir_write, reg_write, mem_req, mem_we, iord, pc_src (each 1 bit), with iord 0=PC/1=ALUOut and pc_src 0=ALU result/1=ALUOut.
REQ-009 SHALL have outputs alu_src_a (2: 0=old PC, 1=rs1, 2=PC), alu_src_b (2: 0=rs2, 1=const 4, 2=imm), alu_op (2: 0=ADD, 1=SUB, 2=by funct), and wb_sel (2: 0=ALUOut, 1=mem data, 2=PC).
REQ-010 SHALL have outputs state (3), illegal (1, sticky trap flag) and instr_count (COUNT_W, retired instructions).

Function
REQ-011 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7; codes 5/6 SHALL go to TRAP.
REQ-012 Default output value SHALL be 0 in any state/condition not listed below.
REQ-013 FETCH: mem_req=1, iord=0, alu_src_a=2, alu_src_b=1, alu_op=ADD; remain while mem_ready=0.
REQ-014 FETCH with mem_ready=1 (Mealy): ir_write=1, pc_write=1, pc_src=0; next DECODE.
REQ-015 DECODE: alu_src_a=0, alu_src_b=2, alu_op=ADD (branch/jump target to ALUOut); next EXEC if opcode is one of 0110011 (R), 0010011 (I), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH), 1101111 (JAL); otherwise TRAP.
REQ-016 EXEC R: alu_src_a=1, alu_src_b=0, alu_op=2 -> WB. EXEC I: alu_src_a=1, alu_src_b=2, alu_op=2 -> WB.
REQ-017 EXEC LOAD/STORE: alu_src_a=1, alu_src_b=2, alu_op=ADD -> MEM.
REQ-018 EXEC BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB; taken = (funct3==000 & zero) | (funct3==001 & !zero); taken -> pc_write=1, pc_src=1; other funct3 -> TRAP; legal -> FETCH.
REQ-019 EXEC JAL: reg_write=1, wb_sel=2, pc_write=1, pc_src=1 -> FETCH.
REQ-020 MEM: mem_req=1, iord=1, mem_we=1 for STORE only; hold while mem_ready=0; on mem_ready STORE -> FETCH, LOAD -> WB.
REQ-021 WB: reg_write=1, wb_sel=1 for LOAD else 0 -> FETCH.
REQ-022 instr_count SHALL increment by 1 on every clock edge on which the state moves to FETCH from EXEC, MEM or WB; wraps modulo 2^COUNT_W.
REQ-023 TRAP: illegal=1, all enables 0, state held until reset; instr_count frozen.
REQ-024 Latency with mem_ready always 1: BRANCH/JAL 3 cycles, R/I/STORE 4, LOAD 5; each mem_ready=0 cycle in FETCH or MEM adds one cycle.
REQ-025 mem_req SHALL stay asserted with stable iord/mem_we until the mem_ready cycle; no request SHALL be abandoned except by reset.

Reset
REQ-026 reset=1 SHALL immediately (no clock) force state=FETCH, illegal=0, instr_count=0, and all registered outputs to 0.
REQ-027 Reset asserted mid-instruction (including mid-MEM store) SHALL drop mem_req/mem_we combinationally; after release the first cycle is FETCH with mem_req=1.

Verification
REQ-028 Reset, then ADD (0110011), mem_ready=1 -> states 0,1,2,4,0; reg_write=1 only in WB; instr_count=1 after cycle 4.
REQ-029 LOAD with mem_ready low 2 cycles in MEM -> MEM held 3 cycles with mem_req=1, iord=1, mem_we=0; WB wb_sel=1; total 7 cycles.
REQ-030 BEQ funct3=000: zero=1 -> pc_write=1, pc_src=1 in EXEC; repeat with zero=0 -> pc_write=0; both return to FETCH after 3 cycles.
REQ-031 opcode 1111111 in DECODE -> TRAP next cycle, illegal=1, held 10 cycles; reset -> FETCH, illegal=0, instr_count=0.
REQ-032 STORE in MEM with mem_ready=0, assert reset asynchronously between edges -> mem_req and mem_we 0 immediately, instr_count unchanged by the aborted store.
REQ-033 Set instr_count near wrap (COUNT_W=4, 15 retired) then retire JAL -> instr_count=0, reg_write=1, wb_sel=2.

Source files
------------

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RV32 subset control unit: FETCH/DECODE/EXEC/MEM/WB sequencer
// with a sticky illegal-instruction trap and a retired-instruction counter.
module riscv_multicycle_ctrl #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem_req,
  output logic               mem_we,
  output logic               iord,
  output logic               pc_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         wb_sel,
  output logic [2:0]         state,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd7;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [2:0]         state_q, state_d;
  logic               illegal_q, illegal_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               taken;

  assign taken = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);

  always_comb begin
    state_d   = state_q;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    iord      = 1'b0;
    pc_src    = 1'b0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_op    = 2'd0;
    wb_sel    = 2'd0;
    case (state_q)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        // Precompute PC+imm into ALUOut for branch/JAL targets.
        alu_src_b = 2'd2;
        case (opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL: state_d = ST_EXEC;
          default: state_d = ST_TRAP;
        endcase
      end
      ST_EXEC: begin
        case (opcode)
          OP_R: begin
            alu_src_a = 2'd1;
            alu_op    = 2'd2;
            state_d   = ST_WB;
          end
          OP_I: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            alu_op    = 2'd2;
            state_d   = ST_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
            state_d   = ST_MEM;
          end
          OP_BRANCH: begin
            alu_src_a = 2'd1;
            alu_op    = 2'd1;
            if ((funct3 == 3'b000) || (funct3 == 3'b001)) begin
              pc_write = taken;
              pc_src   = taken;
              state_d  = ST_FETCH;
            end else begin
              state_d  = ST_TRAP;
            end
          end
          OP_JAL: begin
            reg_write = 1'b1;
            wb_sel    = 2'd2;
            pc_write  = 1'b1;
            pc_src    = 1'b1;
            state_d   = ST_FETCH;
          end
          default: state_d = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (opcode == OP_STORE);
        if (mem_ready) state_d = (opcode == OP_STORE) ? ST_FETCH : ST_WB;
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = (opcode == OP_LOAD) ? 2'd1 : 2'd0;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_TRAP;
    endcase
    // Reset must kill any in-flight memory request without waiting for a clock.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      iord      = 1'b0;
      pc_src    = 1'b0;
      alu_src_a = 2'd0;
      alu_src_b = 2'd0;
      alu_op    = 2'd0;
      wb_sel    = 2'd0;
    end
  end

  always_comb begin
    illegal_d = illegal_q || (state_d == ST_TRAP);
    count_d   = count_q;
    if ((state_d == ST_FETCH) &&
        ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB)))
      count_d = count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Bench for riscv_multicycle_ctrl: latency table, random instruction traces
// built from per-class phase rules, and hand-written reset/trap/wrap cases.
module tb_riscv_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk, reset, zero, mem_ready;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          pc_write, ir_write, reg_write, mem_req, mem_we, iord, pc_src;
  logic [1:0]    alu_src_a, alu_src_b, alu_op, wb_sel;
  logic [2:0]    state;
  logic          illegal;
  logic [CW-1:0] instr_count;

  riscv_multicycle_ctrl #(.COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .wb_sel(wb_sel), .state(state), .illegal(illegal),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cnt = 0;

  typedef struct {
    logic [2:0]  st;
    logic        mr;
    logic        z;
    logic [14:0] o;
  } cyc_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    int         cycles;
    logic [2:0] end_st;
  } vec_t;

  cyc_t tr[$];
  vec_t vecs[10];
  logic [6:0] op_tab[7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h63, 7'h6f};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] dut_outs();
    return {pc_write, ir_write, reg_write, mem_req, mem_we, iord, pc_src,
            alu_src_a, alu_src_b, alu_op, wb_sel};
  endfunction

  function automatic logic [14:0] mk(input logic pw, irw, rw, mq, mw, io, ps,
                                     input logic [1:0] a, b, op, wb);
    return {pw, irw, rw, mq, mw, io, ps, a, b, op, wb};
  endfunction

  function automatic void push(input logic [2:0] st, input logic mr, input logic z,
                               input logic [14:0] o);
    cyc_t c;
    c.st = st; c.mr = mr; c.z = z; c.o = o;
    tr.push_back(c);
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle trace of one instruction; cls: 0 R,1 I,2 LOAD,3 STORE,4 BEQ,5 BNE,6 JAL.
  task automatic build(input int cls, input int wf, input int wm, input logic zb);
    logic tk;
    logic st_op;
    repeat (wf) push(3'd0, 1'b0, rb(), mk(0,0,0,1,0,0,0,2'd2,2'd1,2'd0,2'd0));
    push(3'd0, 1'b1, rb(), mk(1,1,0,1,0,0,0,2'd2,2'd1,2'd0,2'd0));
    push(3'd1, rb(), rb(), mk(0,0,0,0,0,0,0,2'd0,2'd2,2'd0,2'd0));
    case (cls)
      0: push(3'd2, rb(), rb(), mk(0,0,0,0,0,0,0,2'd1,2'd0,2'd2,2'd0));
      1: push(3'd2, rb(), rb(), mk(0,0,0,0,0,0,0,2'd1,2'd2,2'd2,2'd0));
      2, 3: push(3'd2, rb(), rb(), mk(0,0,0,0,0,0,0,2'd1,2'd2,2'd0,2'd0));
      4, 5: begin
        tk = (cls == 4) ? zb : !zb;
        push(3'd2, rb(), zb, mk(tk,0,0,0,0,0,tk,2'd1,2'd0,2'd1,2'd0));
      end
      default: push(3'd2, rb(), rb(), mk(1,0,1,0,0,0,1,2'd0,2'd0,2'd0,2'd2));
    endcase
    if (cls == 2 || cls == 3) begin
      st_op = (cls == 3);
      repeat (wm) push(3'd3, 1'b0, rb(), mk(0,0,0,1,st_op,1,0,2'd0,2'd0,2'd0,2'd0));
      push(3'd3, 1'b1, rb(), mk(0,0,0,1,st_op,1,0,2'd0,2'd0,2'd0,2'd0));
    end
    if (cls <= 2)
      push(3'd4, rb(), rb(), mk(0,0,1,0,0,0,0,2'd0,2'd0,2'd0,(cls == 2) ? 2'd1 : 2'd0));
  endtask

  // Starts and ends aligned to a falling edge.
  task automatic run_trace(input logic [6:0] op, input logic [2:0] f3, input string nm);
    cyc_t c;
    while (tr.size() != 0) begin
      c = tr.pop_front();
      opcode = op; funct3 = f3; zero = c.z; mem_ready = c.mr;
      #2;
      chk({nm, " state"}, 32'(state), 32'(c.st));
      chk({nm, " outs"}, 32'(dut_outs()), 32'(c.o));
      chk({nm, " illegal"}, 32'(illegal), 32'(0));
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input string nm);
    #3 reset = 1'b1;
    #1;
    chk({nm, " rst state"}, 32'(state), 32'(0));
    chk({nm, " rst illegal"}, 32'(illegal), 32'(0));
    chk({nm, " rst count"}, 32'(instr_count), 32'(0));
    chk({nm, " rst outs"}, 32'(dut_outs()), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cls;
    logic [6:0] op;
    logic [2:0] f3;
    reset = 1'b1; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0;
    #3;
    chk("reset state", 32'(state), 32'(0));
    chk("reset illegal", 32'(illegal), 32'(0));
    chk("reset count", 32'(instr_count), 32'(0));
    chk("reset outs", 32'(dut_outs()), 32'(0));
    @(negedge clk);
    reset = 1'b0;

    vecs[0] = '{7'h33, 3'd0, 1'b0, 4, 3'd0};
    vecs[1] = '{7'h13, 3'd0, 1'b0, 4, 3'd0};
    vecs[2] = '{7'h03, 3'd2, 1'b0, 5, 3'd0};
    vecs[3] = '{7'h23, 3'd2, 1'b0, 4, 3'd0};
    vecs[4] = '{7'h63, 3'd0, 1'b1, 3, 3'd0};
    vecs[5] = '{7'h63, 3'd0, 1'b0, 3, 3'd0};
    vecs[6] = '{7'h63, 3'd1, 1'b1, 3, 3'd0};
    vecs[7] = '{7'h6f, 3'd0, 1'b0, 3, 3'd0};
    vecs[8] = '{7'h63, 3'd4, 1'b0, 3, 3'd7};
    vecs[9] = '{7'h7f, 3'd0, 1'b0, 2, 3'd7};
    for (int i = 0; i < 10; i++) begin
      opcode = vecs[i].op; funct3 = vecs[i].f3; zero = vecs[i].z; mem_ready = 1'b1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (state != 3'd0 && state != 3'd7 && n < 20);
      chk($sformatf("vec%0d cycles", i), 32'(n), 32'(vecs[i].cycles));
      chk($sformatf("vec%0d end state", i), 32'(state), 32'(vecs[i].end_st));
      if (vecs[i].end_st == 3'd7) begin
        chk($sformatf("vec%0d illegal", i), 32'(illegal), 32'(1));
        do_reset($sformatf("vec%0d", i));
      end else begin
        cnt = (cnt + 1) % 16;
        chk($sformatf("vec%0d count", i), 32'(instr_count), 32'(cnt));
      end
    end

    for (int i = 0; i < 60; i++) begin
      cls = $urandom_range(0, 6);
      op = op_tab[cls];
      f3 = (cls == 4) ? 3'd0 : (cls == 5) ? 3'd1 : 3'($urandom_range(0, 7));
      build(cls, $urandom_range(0, 2), $urandom_range(0, 2), rb());
      run_trace(op, f3, $sformatf("rnd%0d cls%0d", i, cls));
      cnt = (cnt + 1) % 16;
      chk($sformatf("rnd%0d count", i), 32'(instr_count), 32'(cnt));
    end

    // Store aborted by reset while waiting in MEM.
    opcode = 7'h23; funct3 = 3'd2; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    #2;
    chk("abort mem state", 32'(state), 32'(3));
    chk("abort mem_req", 32'(mem_req), 32'(1));
    chk("abort mem_we", 32'(mem_we), 32'(1));
    @(negedge clk);
    #2;
    chk("abort hold state", 32'(state), 32'(3));
    chk("abort hold count", 32'(instr_count), 32'(cnt));
    #1 reset = 1'b1;
    #1;
    chk("abort mem_req drop", 32'(mem_req), 32'(0));
    chk("abort mem_we drop", 32'(mem_we), 32'(0));
    chk("abort state", 32'(state), 32'(0));
    chk("abort count", 32'(instr_count), 32'(0));
    cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("post-rst state", 32'(state), 32'(0));
    chk("post-rst mem_req", 32'(mem_req), 32'(1));
    @(negedge clk);

    // Illegal opcode traps and holds until reset.
    opcode = 7'h7f; funct3 = 3'd0; mem_ready = 1'b1;
    @(negedge clk);
    #2;
    chk("trap decode state", 32'(state), 32'(1));
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      mem_ready = rb(); zero = rb();
      opcode = 7'($urandom_range(0, 127));
      #2;
      chk($sformatf("trap%0d state", i), 32'(state), 32'(7));
      chk($sformatf("trap%0d illegal", i), 32'(illegal), 32'(1));
      chk($sformatf("trap%0d outs", i), 32'(dut_outs()), 32'(0));
      chk($sformatf("trap%0d count", i), 32'(instr_count), 32'(cnt));
      @(negedge clk);
    end
    do_reset("trap");

    // Counter wrap: 15 retired, then a JAL wraps it to zero.
    for (int i = 0; i < 15; i++) begin
      build(6, $urandom_range(0, 1), 0, rb());
      run_trace(7'h6f, 3'd0, $sformatf("wrap jal%0d", i));
      cnt = cnt + 1;
    end
    chk("wrap pre count", 32'(instr_count), 32'(15));
    build(6, 0, 0, 1'b0);
    run_trace(7'h6f, 3'd0, "wrap last jal");
    chk("wrap count", 32'(instr_count), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
